serial_compare_feeder_msb_first: RTL and testbench

//  Upstream feeder for the MSB-first serial comparator.
//  - Accepts a pair of WIDTH-bit words over a valid/ready handshake.
//  - Shifts both words out MSB first, one bit per clock, on ser_a/ser_b.
//  - Drives the comparator's synchronous clear (cmp_clr).
//  - Captures the comparator's lt/eq/gt outputs on the last bit into a 1-deep result slot with its own handshake.

---
 rtl/serial_compare_feeder_msb_first.sv | 179 +++++++++++++++++
 tb/tb_serial_compare_feeder_msb_first.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_feeder_msb_first.sv
// serial_compare_feeder_msb_first
// Takes an operand pair over valid/ready and shifts both words out MSB first,
// one bit per clock, to a downstream serial magnitude comparator. Drives the
// comparator's synchronous clear and captures its lt/eq/gt verdict on the LSB
// into a one-deep result slot that has its own valid/ready handshake.
module serial_compare_feeder_msb_first #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // operand pair handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    // serial stream towards the comparator
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             cmp_clr,
    // comparator verdict (combinational, includes the current bit)
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    // result slot handshake
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_err
);

    // A one-bit counter is kept even for WIDTH=1 so the ports of the counter
    // logic never collapse to zero width.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic          SINGLE_BIT = (WIDTH == 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic             cmp_clr_q, cmp_clr_d;
    logic             res_valid_q, res_valid_d;
    logic             res_lt_q, res_lt_d;
    logic             res_eq_q, res_eq_d;
    logic             res_gt_q, res_gt_d;
    logic             res_err_q, res_err_d;
    logic             accept;

    // True when exactly one of the three comparator flags is asserted.
    function automatic logic onehot3(input logic lt, input logic eq, input logic gt);
        return (lt & ~eq & ~gt) | (~lt & eq & ~gt) | (~lt & ~eq & gt);
    endfunction

    // A new pair may enter only from IDLE, and only if the result slot is
    // empty or is being popped in this same cycle (so capture never collides).
    assign in_ready = (state_q == IDLE) & (~res_valid_q | res_ready);
    assign accept   = in_valid & in_ready;

    // Next-state logic: operand load, MSB-first shifting and result capture.
    always_comb begin
        state_d     = state_q;
        sha_d       = sha_q;
        shb_d       = shb_q;
        cnt_d       = cnt_q;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        res_valid_d = res_valid_q;
        res_lt_d    = res_lt_q;
        res_eq_d    = res_eq_q;
        res_gt_d    = res_gt_q;
        res_err_d   = res_err_q;

        // Consumer pop; a capture below in the same cycle takes precedence.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sha_d       = in_a;
                    shb_d       = in_b;
                    cnt_d       = CNT_MAX;
                    state_d     = SHIFT;
                    ser_valid_d = 1'b1;
                    ser_first_d = 1'b1;
                    ser_last_d  = SINGLE_BIT;
                end
            end
            SHIFT: begin
                // Shifting every SHIFT cycle, including the LSB one, leaves
                // the shift registers all-zero back in IDLE, so ser_a/ser_b
                // read 0 there without extra gating.
                sha_d = sha_q << 1;
                shb_d = shb_q << 1;
                if (ser_last_q) begin
                    state_d     = IDLE;
                    res_lt_d    = cmp_lt;
                    res_eq_d    = cmp_eq;
                    res_gt_d    = cmp_gt;
                    res_err_d   = ~onehot3(cmp_lt, cmp_eq, cmp_gt);
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q - CNT_ONE;
                    ser_valid_d = 1'b1;
                    ser_last_d  = (cnt_q == CNT_ONE);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear the comparator whenever no word is in flight, and again on
        // the LSB cycle so its state is fresh once that bit has been judged.
        cmp_clr_d = (state_d == IDLE) | ser_last_d;
    end

    // State, datapath and registered outputs; async reset aborts any word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sha_q       <= '0;
            shb_q       <= '0;
            cnt_q       <= '0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            cmp_clr_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_gt_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sha_q       <= sha_d;
            shb_q       <= shb_d;
            cnt_q       <= cnt_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            cmp_clr_q   <= cmp_clr_d;
            res_valid_q <= res_valid_d;
            res_lt_q    <= res_lt_d;
            res_eq_q    <= res_eq_d;
            res_gt_q    <= res_gt_d;
            res_err_q   <= res_err_d;
        end
    end

    assign ser_a     = sha_q[WIDTH-1];
    assign ser_b     = shb_q[WIDTH-1];
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign cmp_clr   = cmp_clr_q;
    assign res_valid = res_valid_q;
    assign res_lt    = res_lt_q;
    assign res_eq    = res_eq_q;
    assign res_gt    = res_gt_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_serial_compare_feeder_msb_first.sv
// Bench for serial_compare_feeder_msb_first: an 8-bit instance with a
// behavioural MSB-first comparator, checked through result/bit scoreboards,
// plus a 1-bit instance exercised directly.
module tb_serial_compare_feeder_msb_first;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- WIDTH=8 instance ----------------
    logic       rst_n, in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       ser_a, ser_b, ser_valid, ser_first, ser_last, cmp_clr;
    logic       cmp_lt, cmp_eq, cmp_gt;
    logic       res_valid, res_ready, res_lt, res_eq, res_gt, res_err;
    logic       force_bad = 1'b0;

    serial_compare_feeder_msb_first #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .ser_a(ser_a), .ser_b(ser_b), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .cmp_clr(cmp_clr),
        .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .res_err(res_err)
    );

    // Behavioural MSB-first comparator: first differing bit decides.
    logic m_lt_q = 1'b0, m_gt_q = 1'b0;
    logic m_lt, m_gt;
    always @(posedge clk) begin
        if (cmp_clr) begin
            m_lt_q <= 1'b0;
            m_gt_q <= 1'b0;
        end else if (ser_valid && !m_lt_q && !m_gt_q) begin
            m_lt_q <= !ser_a && ser_b;
            m_gt_q <= ser_a && !ser_b;
        end
    end
    assign m_lt   = m_lt_q | (!m_lt_q & !m_gt_q & ser_valid & !ser_a & ser_b);
    assign m_gt   = m_gt_q | (!m_lt_q & !m_gt_q & ser_valid & ser_a & !ser_b);
    assign cmp_lt = m_lt | force_bad;
    assign cmp_gt = m_gt;
    assign cmp_eq = !(m_lt | m_gt) | force_bad;

    // ---------------- WIDTH=1 instance ----------------
    logic       rst_n1, in_valid1, in_ready1;
    logic [0:0] in_a1, in_b1;
    logic       ser_a1, ser_b1, ser_valid1, ser_first1, ser_last1, cmp_clr1;
    logic       cmp_lt1, cmp_eq1, cmp_gt1;
    logic       res_valid1, res_ready1, res_lt1, res_eq1, res_gt1, res_err1;

    serial_compare_feeder_msb_first #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .ser_a(ser_a1), .ser_b(ser_b1), .ser_valid(ser_valid1),
        .ser_first(ser_first1), .ser_last(ser_last1), .cmp_clr(cmp_clr1),
        .cmp_lt(cmp_lt1), .cmp_eq(cmp_eq1), .cmp_gt(cmp_gt1),
        .res_valid(res_valid1), .res_ready(res_ready1),
        .res_lt(res_lt1), .res_eq(res_eq1), .res_gt(res_gt1), .res_err(res_err1)
    );

    logic n_lt_q = 1'b0, n_gt_q = 1'b0;
    always @(posedge clk) begin
        if (cmp_clr1) begin
            n_lt_q <= 1'b0;
            n_gt_q <= 1'b0;
        end else if (ser_valid1 && !n_lt_q && !n_gt_q) begin
            n_lt_q <= !ser_a1 && ser_b1;
            n_gt_q <= ser_a1 && !ser_b1;
        end
    end
    assign cmp_lt1 = n_lt_q | (!n_lt_q & !n_gt_q & ser_valid1 & !ser_a1 & ser_b1);
    assign cmp_gt1 = n_gt_q | (!n_lt_q & !n_gt_q & ser_valid1 & ser_a1 & !ser_b1);
    assign cmp_eq1 = !(cmp_lt1 | cmp_gt1);

    // ---------------- scoreboards ----------------
    logic [3:0] res_q[$];   // {lt, eq, gt, err}
    logic [3:0] ser_q[$];   // {ser_a, ser_b, ser_first, ser_last}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Serial-stream monitor: every live bit must match the next expected bit.
    always begin
        logic [3:0] e;
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (ser_valid) begin
                if (ser_q.size() == 0) begin
                    flag("ser_unexpected_bit");
                end else begin
                    e = ser_q.pop_front();
                    check("ser_bit", {ser_a, ser_b, ser_first, ser_last}, e);
                    check("cmp_clr_in_shift", cmp_clr, ser_last);
                end
            end else begin
                check("idle_ser_and_clr", {ser_a, ser_b, ser_first, ser_last, cmp_clr}, 5'b00001);
            end
        end
    end

    // Result monitor: each pop must match the next expected verdict.
    always begin
        logic [3:0] e;
        @(negedge clk);
        #3;
        if (rst_n && res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                flag("res_unexpected_pop");
            end else begin
                e = res_q.pop_front();
                check("res_flags", {res_lt, res_eq, res_gt, res_err}, e);
            end
        end
    end

    // Offer one pair, wait (bounded) for acceptance, queue expectations.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] exp_res, output int h);
        int n;
        n = 0;
        h = -1;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            flag("send_timeout");
            in_valid = 1'b0;
        end else begin
            h = cyc;
            res_q.push_back(exp_res);
            for (int i = 7; i >= 0; i--) begin
                ser_q.push_back({a[i], b[i], (i == 7), (i == 0)});
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((res_q.size() != 0 || ser_q.size() != 0) && n < 100) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (res_q.size() != 0 || ser_q.size() != 0) flag("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
        rst_n1 = 1'b0; in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; res_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        // reset values
        check("rst_in_ready", in_ready, 1);
        check("rst_cmp_clr", cmp_clr, 1);
        check("rst_ser", {ser_a, ser_b, ser_valid, ser_first, ser_last}, 5'b0);
        check("rst_res", {res_valid, res_lt, res_eq, res_gt, res_err}, 5'b0);
        check("rst1_outputs", {in_ready1, cmp_clr1, ser_valid1, res_valid1}, 4'b1100);
        @(negedge clk);
        rst_n = 1'b1;
        rst_n1 = 1'b1;

        // equal operands, result latency
        send(8'hA5, 8'hA5, 4'b0100, h);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!res_valid) flag("latency_timeout");
        else check("res_latency", cyc - h, 9);

        // greater, first/last markers checked by the stream monitor
        send(8'h80, 8'h7F, 4'b0010, h);
        // less, clear pulse on LSB and in IDLE checked by the stream monitor
        send(8'h00, 8'h01, 4'b1000, h);

        // in_valid during SHIFT is ignored
        send(8'h3C, 8'hC3, 4'b1000, h);
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h00;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("in_ready_in_shift", in_ready, 0);
        end
        in_valid = 1'b0;
        wait_drain();

        // result slot back-pressure, then simultaneous pop and accept
        @(negedge clk);
        res_ready = 1'b0;
        send(8'h12, 8'h34, 4'b1000, h);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!res_valid) flag("held_result_timeout");
        fork
            send(8'hF0, 8'h0F, 4'b0010, h);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    check("in_ready_slot_full", in_ready, 0);
                    check("held_result", {res_valid, res_lt, res_eq, res_gt, res_err}, 5'b11000);
                end
                @(negedge clk);
                res_ready = 1'b1;
            end
        join
        wait_drain();

        // comparator reporting a non-one-hot verdict
        force_bad = 1'b1;
        send(8'h55, 8'h55, 4'b1101, h);
        wait_drain();
        force_bad = 1'b0;

        // asynchronous reset at bit 3 aborts the word
        send(8'hC3, 8'h5A, 4'b0010, h);
        repeat (5) @(negedge clk);
        #1;
        check("pre_abort_live", {ser_valid, ser_first, ser_last}, 3'b100);
        #1;
        rst_n = 1'b0;
        #1;
        ser_q.delete();
        res_q.delete();
        check("abort_ser", {ser_a, ser_b, ser_valid, ser_first, ser_last}, 5'b0);
        check("abort_ctrl", {in_ready, cmp_clr, res_valid}, 3'b110);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h10, 8'h20, 4'b1000, h);
        wait_drain();
        repeat (3) @(negedge clk);

        // single-bit instance: one SHIFT cycle with first and last together
        @(negedge clk);
        in_a1 = 1'b1;
        in_b1 = 1'b0;
        in_valid1 = 1'b1;
        #1;
        check("w1_in_ready", in_ready1, 1);
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        check("w1_shift", {ser_valid1, ser_first1, ser_last1, ser_a1, ser_b1, cmp_clr1}, 6'b111101);
        @(negedge clk);
        #1;
        check("w1_result", {res_valid1, res_lt1, res_eq1, res_gt1, res_err1}, 5'b10010);
        check("w1_back_idle", {ser_valid1, in_ready1}, 2'b01);

        @(negedge clk);
        #4;
        check("res_queue_empty", res_q.size(), 0);
        check("ser_queue_empty", ser_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
